// File: rtl/spi_sclk_engine_if.sv
// Control/status bundle between the APB register block, the SCLK engine and the shift datapath.
interface spi_sclk_engine_if #(
  parameter int unsigned PRE_W = 3,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned LEN_W = 5
);
  logic             start;
  logic             abort;
  logic             cpol;
  logic             cpha;
  logic [PRE_W-1:0] spr;
  logic [SEL_W-1:0] sppr;
  logic [LEN_W-1:0] frame_len;
  logic             sclk;
  logic             sample;
  logic             shift;
  logic             busy;
  logic             done;
  logic [LEN_W:0]   bit_cnt;

  modport master (
    output start, abort, cpol, cpha, spr, sppr, frame_len,
    input  sclk, sample, shift, busy, done, bit_cnt
  );

  modport slave (
    input  start, abort, cpol, cpha, spr, sppr, frame_len,
    output sclk, sample, shift, busy, done, bit_cnt
  );
endinterface

// File: rtl/spi_sclk_engine.sv
// SPI master serial-clock engine: one framed SCLK burst per start (lead, 2N edges, trail, done)
// with one-cycle sample/shift strobes aligned to the SCLK edges.
module spi_sclk_engine #(
  parameter int unsigned PRE_W = 3,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned LEN_W = 5
) (
  input logic              clk_i,
  input logic              rst_n,
  spi_sclk_engine_if.slave bus
);
  localparam int unsigned CNT_W = SEL_W + (1 << PRE_W);
  localparam int unsigned EDG_W = LEN_W + 2;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, h_last, h_last_nx, h_req;
  logic [EDG_W-1:0] edge_cnt, edge_cnt_nx, edge_last, edge_last_nx, edge_k;
  logic [PRE_W:0]   sh_amt;
  logic             cpol_q, cpol_nx, cpha_q, cpha_nx;
  logic             sclk_q, sclk_nx, sample_q, sample_nx, shift_q, shift_nx, done_q, done_nx;
  logic [LEN_W:0]   bit_cnt_q, bit_cnt_nx;
  logic             accept, tick;

  assign sh_amt = (PRE_W+1)'(bus.spr) + (PRE_W+1)'(1);
  // H-1 formed as (sppr << s) | ((1 << s) - 1), equal to ((sppr+1) << s) - 1 but fits CNT_W bits
  assign h_req  = (CNT_W'(bus.sppr) << sh_amt) | ((CNT_W'(1) << sh_amt) - CNT_W'(1));

  assign accept = (state == IDLE) && bus.start && !bus.abort;
  assign tick   = (cnt == h_last);
  assign edge_k = edge_cnt + EDG_W'(1);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    edge_cnt_nx  = edge_cnt;
    h_last_nx    = h_last;
    edge_last_nx = edge_last;
    cpol_nx      = cpol_q;
    cpha_nx      = cpha_q;
    sclk_nx      = sclk_q;
    sample_nx    = 1'b0;
    shift_nx     = 1'b0;
    done_nx      = 1'b0;
    bit_cnt_nx   = sample_q ? bit_cnt_q + 1'b1 : bit_cnt_q;

    if (state == IDLE) begin
      sclk_nx     = bus.cpol;
      cnt_nx      = '0;
      edge_cnt_nx = '0;
      if (accept) begin
        state_nx     = LEAD;
        h_last_nx    = h_req;
        edge_last_nx = EDG_W'({bus.frame_len, 1'b0}) + EDG_W'(2);
        cpol_nx      = bus.cpol;
        cpha_nx      = bus.cpha;
        bit_cnt_nx   = '0;
      end
    end else if (bus.abort) begin
      state_nx = IDLE;
      sclk_nx  = bus.cpol;
    end else begin
      cnt_nx = tick ? '0 : cnt + 1'b1;
      if (tick) begin
        if (state == TRAIL) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          sclk_nx  = bus.cpol;
        end else begin
          // Odd edges sample when cpha=0, even edges when cpha=1; the final edge never shifts.
          sclk_nx     = ~sclk_q;
          edge_cnt_nx = edge_k;
          sample_nx   = edge_k[0] ^ cpha_q;
          shift_nx    = cpha_q ? edge_k[0] : (!edge_k[0] && (edge_k != edge_last));
          state_nx    = (edge_k == edge_last) ? TRAIL : XFER;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      edge_cnt  <= '0;
      h_last    <= '0;
      edge_last <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      edge_cnt  <= edge_cnt_nx;
      h_last    <= h_last_nx;
      edge_last <= edge_last_nx;
      cpol_q    <= cpol_nx;
      cpha_q    <= cpha_nx;
      sclk_q    <= sclk_nx;
      sample_q  <= sample_nx;
      shift_q   <= shift_nx;
      done_q    <= done_nx;
      bit_cnt_q <= bit_cnt_nx;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.sample  = sample_q;
  assign bus.shift   = shift_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.bit_cnt = bit_cnt_q;
endmodule

// File: tb/tb_spi_sclk_engine.sv
// Randomised bench for spi_sclk_engine against a timing-arithmetic reference model.
module tb_spi_sclk_engine;
  localparam int unsigned PRE_W = 3;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned LEN_W = 5;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  spi_sclk_engine_if #(.PRE_W(PRE_W), .SEL_W(SEL_W), .LEN_W(LEN_W)) bus ();

  spi_sclk_engine #(.PRE_W(PRE_W), .SEL_W(SEL_W), .LEN_W(LEN_W)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is described by its start cycle offset d, H, N and captured mode.
  bit m_active = 1'b0;
  int m_d = 0, m_h = 2, m_n = 1;
  bit m_cpol = 1'b0, m_cpha = 1'b0;
  bit m_live = 1'b0;
  int m_bit = 0;
  bit e_samp_now = 1'b0;
  bit last_done = 1'b0;
  int o_samp = 0, o_shift = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    bit e_busy, e_done, e_sclk, e_samp, e_shift;
    int k;
    e_busy = 1'b0; e_done = 1'b0; e_samp = 1'b0; e_shift = 1'b0; e_sclk = m_live;
    if (m_active) begin
      if (m_d < (2*m_n+1)*m_h) begin
        e_busy = 1'b1;
        k = m_d / m_h;
        e_sclk = m_cpol ^ ((k % 2) == 1);
        if ((m_d % m_h) == 0 && k > 0) begin
          if ((k % 2) == 1) begin
            if (m_cpha) e_shift = 1'b1; else e_samp = 1'b1;
          end else begin
            if (m_cpha) e_samp = 1'b1; else if (k < 2*m_n) e_shift = 1'b1;
          end
        end
      end else begin
        e_done = 1'b1;
      end
    end
    check("busy", bus.busy, e_busy);
    check("done", bus.done, e_done);
    check("sclk", bus.sclk, e_sclk);
    check("sample", bus.sample, e_samp);
    check("shift", bus.shift, e_shift);
    check("bit_cnt", bus.bit_cnt, m_bit);
    e_samp_now = e_samp;
    last_done  = bus.done;
    if (bus.sample) o_samp++;
    if (bus.shift) o_shift++;
  endtask

  // Check the current cycle, then drive inputs for the next clock edge and advance the model.
  task automatic step(input bit st, input bit ab, input bit cp, input bit ch,
                      input int sp, input int spp, input int ln);
    @(negedge clk_i);
    check_cycle();
    bus.start = st; bus.abort = ab; bus.cpol = cp; bus.cpha = ch;
    bus.spr = PRE_W'(sp); bus.sppr = SEL_W'(spp); bus.frame_len = LEN_W'(ln);
    if (e_samp_now) m_bit++;
    if (m_active && m_d < (2*m_n+1)*m_h) begin
      if (ab) m_active = 1'b0; else m_d++;
    end else begin
      m_active = 1'b0;
      if (st && !ab) begin
        m_active = 1'b1; m_d = 0;
        m_h = (spp + 1) << (sp + 1); m_n = ln + 1;
        m_cpol = cp; m_cpha = ch; m_bit = 0;
      end
    end
    m_live = cp;
  endtask

  task automatic frame(input bit cp, input bit ch, input int sp, input int spp, input int ln,
                       input int abort_edge, input bit scramble, input bit hold, input bit issue);
    int h, fin, ab_i, done_at;
    bit st, ab, c_p, c_h;
    int s1, s2, s3;
    h = (spp + 1) << (sp + 1);
    fin = (2*(ln+1) + 1) * h;
    ab_i = (abort_edge > 0) ? abort_edge * h : -1;
    done_at = -1;
    o_samp = 0; o_shift = 0;
    if (issue) step(1'b1, 1'b0, cp, ch, sp, spp, ln);
    for (int i = 0; i <= fin + 4; i++) begin
      st = hold; ab = (i == ab_i);
      c_p = cp; c_h = ch; s1 = sp; s2 = spp; s3 = ln;
      if (scramble && i < fin && (ab_i < 0 || i < ab_i)) begin
        c_p = 1'($urandom_range(1)); c_h = 1'($urandom_range(1));
        s1 = $urandom_range(7); s2 = $urandom_range(7); s3 = $urandom_range(31);
        st = hold || ($urandom_range(3) == 0);
      end
      step(st, ab, c_p, c_h, s1, s2, s3);
      if (last_done) begin
        done_at = i;
        break;
      end
      if (ab_i >= 0 && i >= ab_i + 3) break;
    end
    if (ab_i < 0) begin
      check("done_time", done_at, fin);
      check("n_samples", o_samp, ln + 1);
      check("n_shifts", o_shift, ch ? ln + 1 : ln);
    end else begin
      check("abort_no_done", done_at, -1);
    end
  endtask

  initial begin
    bit pend;
    bit cp, ch, hold, scr;
    int sp, spp, ln, abe;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.spr = '0; bus.sppr = '0; bus.frame_len = '0;

    repeat (3) @(negedge clk_i);
    check("rst_sclk", bus.sclk, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sample", bus.sample, 0);
    check("rst_shift", bus.shift, 0);
    check("rst_bit_cnt", bus.bit_cnt, 0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    // Baseline H=2, N=8 across all four modes
    frame(1'b0, 1'b0, 0, 0, 7, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 7);
    check("t1_bit_cnt", bus.bit_cnt, 8);
    for (int m = 1; m < 4; m++) begin
      repeat (2) step(1'b0, 1'b0, 1'((m >> 1) & 1), 1'b0, 0, 0, 7);
      frame(1'((m >> 1) & 1), 1'(m & 1), 0, 0, 7, 0, 1'b0, 1'b0, 1'b1);
    end

    // Largest half period with N=1
    frame(1'b0, 1'b0, 7, 7, 0, 0, 1'b0, 1'b0, 1'b1);
    frame(1'b1, 1'b1, 7, 7, 0, 0, 1'b0, 1'b0, 1'b1);

    // N=1 with each phase
    frame(1'b0, 1'b0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b1, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1);

    // Back-to-back via start held through done, then config churn and starts while busy
    frame(1'b0, 1'b0, 0, 0, 7, 0, 1'b0, 1'b1, 1'b1);
    frame(1'b0, 1'b0, 0, 0, 7, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 7);
    frame(1'b0, 1'b0, 0, 0, 7, 0, 1'b1, 1'b0, 1'b1);

    // Abort at edge 5, then abort+start together while idle
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 7);
    frame(1'b0, 1'b0, 0, 0, 7, 5, 1'b0, 1'b0, 1'b1);
    check("abort_bit_cnt", bus.bit_cnt, 3);
    check("abort_busy", bus.busy, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 7);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 7);
    check("abst_busy", bus.busy, 0);

    // Asynchronous reset mid-frame with cpol=1
    step(1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 7);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 7);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sclk", bus.sclk, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_bit_cnt", bus.bit_cnt, 0);
    bus.cpol = 1'b0; bus.start = 1'b0;
    m_active = 1'b0; m_bit = 0; m_live = 1'b0; e_samp_now = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    // Randomised frames
    pend = 1'b0;
    cp = 1'b0; ch = 1'b0; sp = 0; spp = 0; ln = 0;
    for (int f = 0; f < 40; f++) begin
      if (!pend) begin
        cp = 1'($urandom_range(1)); ch = 1'($urandom_range(1));
        sp = $urandom_range(2); spp = $urandom_range(3); ln = $urandom_range(7);
        for (int g = 0; g < int'($urandom_range(3)); g++) begin
          if ($urandom_range(2) == 0) step(1'b1, 1'b1, 1'($urandom_range(1)), 1'b0, 0, 0, 0);
          else step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 0, 0, 0);
        end
      end
      abe  = ($urandom_range(3) == 0) ? $urandom_range(1, 2*(ln+1)) : 0;
      scr  = ($urandom_range(2) == 0);
      hold = (abe == 0) && ($urandom_range(3) == 0);
      frame(cp, ch, sp, spp, ln, abe, scr, hold, !pend);
      pend = hold;
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
